pool2d_stream: RTL

- Parametrised streaming 2-D pooling engine; successor to the fixed 2x2 max-pooling stage.
- Sits between the activation (sigmoid) stage and the next conv/FC stage.
- Consumes one raster-order pixel per enabled cycle, channel after channel.
- Emits one pooled value per completed POOLxPOOL window, in max or average mode selected per frame.

---
 rtl/pool2d_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming POOLxPOOL max/average pooling over raster-order, channel-major frames.
// Optional feature macro POOL2D_RELU_EN clamps negative pooled results to zero.
module pool2d_stream #(
    parameter int DATA_W   = 16,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int CHANNELS = 5,
    parameter int POOL     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     mode,
    input  logic                     frame_start_in,
    input  logic                     line_start_in,
    input  logic                     frame_end_in,
    input  logic signed [DATA_W-1:0] sig_layer,
    output logic signed [DATA_W-1:0] max_layer,
    output logic                     valid,
    output logic                     frame_start_out,
    output logic                     line_start_out,
    output logic                     frame_end_out,
    output logic                     sync_err
);
    localparam int LOG2P = (POOL == 4) ? 2 : 1;
    localparam int SHIFT = 2 * LOG2P;
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int NWIN  = IMG_W / POOL;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WIN_W = COL_W - LOG2P;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(POOL - 1);
    localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(POOL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic signed [ACC_W-1:0] combine(
        input logic                    avg,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return avg ? (a + b) : ((a > b) ? a : b);
    endfunction

    state_t                    r_state;
    logic [COL_W-1:0]          r_col;
    logic [ROW_W-1:0]          r_row;
    logic [CH_W-1:0]           r_chan;
    logic                      r_mode;
    logic signed [ACC_W-1:0]   r_colacc;
    logic signed [ACC_W-1:0]   r_linebuf [NWIN];
    logic signed [DATA_W-1:0]  r_data;
    logic                      r_valid, r_fs, r_ls, r_fe, r_err;

    logic                      w_accept, w_emit, w_frame_last, w_ls_exp;
    logic                      w_col_first, w_col_close, w_row_first, w_row_close;
    logic [WIN_W-1:0]          w_win;
    logic signed [ACC_W-1:0]   w_pix, w_col_part, w_win_part;
    logic signed [DATA_W-1:0]  w_result, w_out;

    assign w_pix        = ACC_W'(sig_layer);
    assign w_col_first  = (r_col[LOG2P-1:0] == '0);
    assign w_col_close  = (r_col[LOG2P-1:0] == '1);
    assign w_row_first  = (r_row[LOG2P-1:0] == '0);
    assign w_row_close  = (r_row[LOG2P-1:0] == '1);
    assign w_win        = r_col[COL_W-1:LOG2P];
    assign w_frame_last = (r_col == COL_LAST) && (r_row == ROW_LAST) && (r_chan == CH_LAST);
    assign w_ls_exp     = (r_col == COL_LAST) && !((r_row == ROW_LAST) && (r_chan == CH_LAST));
    assign w_accept     = (r_state == RUN) && ena && !frame_start_in;
    assign w_emit       = w_accept && w_col_close && w_row_close;

    // Horizontal partial lives in r_colacc; vertical partial is kept per window in the line buffer.
    assign w_col_part = w_col_first ? w_pix : combine(r_mode, r_colacc, w_pix);
    assign w_win_part = w_row_first ? w_col_part : combine(r_mode, r_linebuf[w_win], w_col_part);
    assign w_result   = r_mode ? DATA_W'(w_win_part >>> SHIFT) : DATA_W'(w_win_part);

`ifdef POOL2D_RELU_EN
    assign w_out = w_result[DATA_W-1] ? '0 : w_result;
`else
    assign w_out = w_result;
`endif

    // NOTE: the line buffer has no reset; each entry is rewritten by the first line of a pooled row before it is read.
    always_ff @(posedge clk) begin
        if (w_accept && w_col_close)
            r_linebuf[w_win] <= w_win_part;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_chan   <= '0;
            r_mode   <= 1'b0;
            r_colacc <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_fs     <= 1'b0;
            r_ls     <= 1'b0;
            r_fe     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_fs    <= 1'b0;
            r_ls    <= 1'b0;
            r_fe    <= 1'b0;
            if (frame_start_in) begin
                // A start while running aborts the frame; a start carrying a pixel drops it.
                if (ena || (r_state == RUN))
                    r_err <= 1'b1;
                r_state <= RUN;
                r_col   <= '0;
                r_row   <= '0;
                r_chan  <= '0;
                r_mode  <= mode;
            end else if (ena) begin
                if (r_state == IDLE) begin
                    r_err <= 1'b1;
                end else begin
                    r_colacc <= w_col_part;
                    if ((line_start_in != w_ls_exp) || (frame_end_in != w_frame_last))
                        r_err <= 1'b1;
                    if (w_emit) begin
                        r_valid <= 1'b1;
                        r_data  <= w_out;
                        r_fs    <= (r_chan == '0) && (r_row == ROW_WIN0) && (r_col == COL_WIN0);
                        r_ls    <= w_ls_exp;
                        r_fe    <= w_frame_last;
                    end
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        if (r_row == ROW_LAST) begin
                            r_row <= '0;
                            if (r_chan == CH_LAST) begin
                                r_chan  <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_chan <= r_chan + CH_W'(1);
                            end
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            end
        end
    end

    assign max_layer       = r_data;
    assign valid           = r_valid;
    assign frame_start_out = r_fs;
    assign line_start_out  = r_ls;
    assign frame_end_out   = r_fe;
    assign sync_err        = r_err;
endmodule
